// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU between register-file read and writeback.
//   Single-cycle ops: result registered one cycle after accept.
//   MUL: iterative shift-add over WIDTH cycles, full 2*WIDTH product.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operation handshake (aluctrl, din1, din2)
//   out_valid/out_ready   result handshake (dout, dout_hi, zero)
//   dout                  result (low half of product for MUL)
//   dout_hi               high half of MUL product, 0 for other ops
//   zero                  dout == 0, registered with dout
//   busy                  high while the multiplier is iterating
module alu_mc #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic             zero,
  output logic             busy
);

  localparam logic [0:0]     S_IDLE   = 1'b0;
  localparam logic [0:0]     S_MUL    = 1'b1;
  localparam logic [3:0]     OP_MUL   = 4'b0011;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [0:0]         state;
  logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier;  // multiplier, shifted right (LSB consumed first)
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;

  logic               fire, is_mul, mul_last, load;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     shamt;
  logic               sh_big;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign is_mul   = (aluctrl == OP_MUL);
  assign busy     = (state == S_MUL);
  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  // a result lands in the output registers this cycle
  assign load     = (fire && !is_mul) || mul_last;

  // any set bit above the low SHW bits means the shift is >= WIDTH
  assign shamt  = din2[SHW-1:0];
  assign sh_big = |din2[WIDTH-1:SHW];

  always_comb begin
    alu_res = din1;
    case (aluctrl)
      4'b0001: alu_res = din1 + din2;
      4'b0010: alu_res = din1 - din2;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, (din1 < din2)};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (din1 == din2)};
      4'b0110: alu_res = din1 | din2;
      4'b0111: alu_res = din1 & din2;
      4'b1001: alu_res = din1 ^ din2;
      4'b1010: alu_res = ~din1;
      4'b1011: alu_res = sh_big ? '0 : (din1 << shamt);
      4'b1100: alu_res = sh_big ? {WIDTH{din1[WIDTH-1]}}
                                : WIDTH'($signed(din1) >>> shamt);
      4'b1101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(din1) < $signed(din2))};
      4'b1110: alu_res = sh_big ? '0 : (din1 >> shamt);
      default: alu_res = din1;  // mv, 0000, 1111
    endcase
  end

  // control: state and result-valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && fire && is_mul) state <= S_MUL;
      else if (mul_last)                     state <= S_IDLE;
      // a fresh load wins over a drain in the same cycle
      if (load)           out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  // multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_IDLE) begin
      if (fire && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, din1};
        mplier <= din2;
        acc    <= '0;
        cnt    <= '0;
      end
    end else begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // result registers; only written on load so they hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      dout_hi <= '0;
      zero    <= 1'b1;
    end else if (mul_last) begin
      dout    <= acc_nxt[WIDTH-1:0];
      dout_hi <= acc_nxt[2*WIDTH-1:WIDTH];
      zero    <= (acc_nxt[WIDTH-1:0] == '0);
    end else if (fire && !is_mul) begin
      dout    <= alu_res;
      dout_hi <= '0;
      zero    <= (alu_res == '0);
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the datapath ALU, sitting between the register-file read stage and writeback.
- Single-cycle ops complete with 1-cycle registered latency.
- MUL runs as an iterative shift-add over WIDTH cycles and returns the full 2*WIDTH product.
- Operands enter and results leave through valid/ready handshakes, so the control unit can stall on MUL.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount bits taken from din2 (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept an operation this cycle
aluctrl  in  4  opcode
din1  in  WIDTH  operand A
din2  in  WIDTH  operand B / shift amount
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer takes result this cycle
dout  out  WIDTH  result (low half for MUL)
dout_hi  out  WIDTH  high half of MUL product; 0 for all other ops
zero  out  1  dout == 0, registered with dout
busy  out  1  high while in MUL state

Behaviour:
- Opcodes: 0001 add, 0010 sub, 0011 mul, 0100 islt, 0101 iseq, 0110 or, 0111 and, 1000 mv, 1001 xor, 1010 not, 1011 slli, 1100 srai, 1101 islts, 1110 srli. 0000/1111 behave as mv.
- Add/sub wrap modulo 2^WIDTH, with no carry or overflow output.
- islt: 1 if din1 < din2, unsigned, strict. islts: same, two's-complement signed. iseq: 1 if equal. Compare results are zero-extended to WIDTH.
- not: ~din1. mv: din1.
- Shifts use the full din2 value. If din2 >= WIDTH: slli/srli give 0, srai gives all copies of din1[WIDTH-1]. Otherwise the amount is din2[SHW-1:0].
- A handshake fires when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so a result can be drained and a new op accepted in the same cycle.
- FSM states: IDLE, MUL.
  - IDLE, non-mul fire: result computed combinationally and registered. out_valid=1 next cycle (latency 1), state stays IDLE.
  - IDLE, mul fire: latch din1/din2 into multiplicand/multiplier, clear the 2*WIDTH accumulator and a counter. Go to MUL, busy=1.
  - MUL: one multiplier bit per cycle, LSB first; accumulator += multiplicand<<i when the bit is set. Exactly WIDTH cycles.
  - After the last iteration: {dout_hi,dout} <= product, out_valid=1, state returns to IDLE.
  - MUL latency: out_valid rises WIDTH+1 cycles after the accept edge. in_ready=0 throughout MUL.
- Operands captured at accept are used for the whole operation; din1/din2/aluctrl changes during MUL are ignored.
- out_valid clears on out_ready && out_valid unless a new result loads in that same cycle, in which case it stays 1.
- dout/dout_hi/zero hold stable while out_valid && !out_ready.
- Reset (asynchronous, any state including mid-MUL):
  - state=IDLE, out_valid=0, dout=0, dout_hi=0, zero=1, busy=0, accumulator and counter cleared.
  - in_ready goes high combinationally after reset release.
  - Any in-flight MUL is discarded and no out_valid is ever produced for it.
- in_valid asserted while in_ready=0: no capture. The source must hold its request, which is taken once in_ready rises.

Test Plan:
- Reset, then add 0x7FFF+0x0001 with out_ready=1 -> next cycle out_valid=1, dout=0x8000, zero=0. Then sub 5-5 -> dout=0, zero=1.
- mul 0xFFFF*0xFFFF at WIDTH=16 -> busy for 16 cycles, in_ready=0; out_valid at cycle 17, dout=0x0001, dout_hi=0xFFFE. Repeat with 0x0000*0x1234 -> dout=0, dout_hi=0, zero=1.
- Back-to-back: or 0x00F0|0x0F00 then xor 0xFFFF^0x00FF with out_ready=0 after the first result -> first result 0x0FF0 held and in_ready=0. Raise out_ready -> xor accepted the same cycle; next result 0xFF00.
- Shifts: srai 0x8000 by 3 -> 0xF000; srai 0x8000 by 20 -> 0xFFFF; slli 0x0001 by 16 -> 0x0000; srli 0x8000 by 15 -> 0x0001.
- Compares: islt 0xFFFF,0x0001 -> 0; islts 0xFFFF,0x0001 -> 1; islt 3,3 -> 0; iseq 3,3 -> 1. Opcodes 0000 and 1111 with din1=0xABCD -> 0xABCD.
- Assert rst_n low at MUL cycle 7 of 3*4 -> all outputs at reset values immediately. After release, no out_valid appears; a new add 3+4 returns 7 with latency 1.
